// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory-access stage: memory op
// encodings, FSM state encoding, access-size and load-extension helpers.
package mem_stage_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Number of bytes moved by an op; 0 for non-memory codes.
   function automatic logic [2:0] op_size(input logic [3:0] op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: op_size = 3'd1;
         MEM_LH, MEM_LHU, MEM_SH: op_size = 3'd2;
         MEM_LW, MEM_SW:          op_size = 3'd4;
         default:                 op_size = 3'd0;
      endcase
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Sign-extend LB/LH, zero-extend LBU/LHU, word passes unchanged.
   function automatic logic [31:0] ext_load(input logic [3:0] op, input logic [31:0] raw);
      case (op)
         MEM_LB:  ext_load = {{24{raw[7]}}, raw[7:0]};
         MEM_LH:  ext_load = {{16{raw[15]}}, raw[15:0]};
         MEM_LBU: ext_load = {24'h0, raw[7:0]};
         MEM_LHU: ext_load = {16'h0, raw[15:0]};
         default: ext_load = raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational assembly of captured load bytes (plus the byte currently
// on the RAM read port as the most significant one) and sign/zero extension.
module mem_load_extend
   import mem_stage_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [23:0] bytes_i,
   input  logic [7:0]  last_i,
   output logic [31:0] data_o
);

   logic [31:0] raw;

   // Place the final byte at the top of the access, then extend.
   always_comb begin
      raw = '0;
      case (op_size(op_i))
         3'd1:    raw = {24'h0, last_i};
         3'd2:    raw = {16'h0, last_i, bytes_i[7:0]};
         default: raw = {last_i, bytes_i};
      endcase
      data_o = ext_load(op_i, raw);
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores over a synchronous
// byte RAM, pipeline stall generation, registered write-back and forwarding.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip RAM and
// complete with misalign_o=1.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] mem_w_data_i,
   input  logic [3:0]        mem_op_i,
   input  logic [7:0]        ram_din_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   output logic              stall_req_o,
   output logic              valid_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [4:0]        fwd_rd_o,
   output logic [DATA_W-1:0] fwd_data_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   state_e            state_q;
   logic [2:0]        step_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       sdata_q;
   logic [3:0]        op_q;
   logic [4:0]        rd_q;
   logic              rwe_q;
   logic [23:0]       bytes_q;

   logic              valid_q;
   logic [4:0]        wd_q;
   logic              wreg_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_wr_q;
   logic [7:0]        ram_dout_q;
`ifdef MEM_MISALIGN_TRAP_EN
   logic              misalign_q;
`endif

   logic              is_mem_d;
   logic              is_ld_d;
   logic [2:0]        size_c;
   logic [3:0]        step_nx_d;
   logic              more_d;
   logic [ADDR_W-1:0] addr_nx_d;
   logic [7:0]        store_byte_d;
   logic [31:0]       load_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic [2:0]        size_in;
   logic              misalign_d;
`endif

   mem_load_extend u_ext (
      .op_i    (op_q),
      .bytes_i (bytes_q),
      .last_i  (ram_din_i),
      .data_o  (load_data)
   );

   // Decode of the incoming op and next-byte bookkeeping for the active access.
   always_comb begin
      is_ld_d   = is_load(mem_op_i);
      is_mem_d  = is_ld_d || is_store(mem_op_i);
      size_c    = op_size(op_q);
      step_nx_d = {1'b0, step_q} + 4'd1;
      more_d    = step_nx_d < {1'b0, size_c};
      addr_nx_d = addr_q + ADDR_W'(step_nx_d);
      case (step_nx_d[1:0])
         2'd1:    store_byte_d = sdata_q[15:8];
         2'd2:    store_byte_d = sdata_q[23:16];
         2'd3:    store_byte_d = sdata_q[31:24];
         default: store_byte_d = sdata_q[7:0];
      endcase
`ifdef MEM_MISALIGN_TRAP_EN
      size_in    = op_size(mem_op_i);
      misalign_d = ((size_in == 3'd2) && wdata_i[0]) ||
                   ((size_in == 3'd4) && (wdata_i[1:0] != 2'b00));
`endif
   end

   // Main FSM: accept, byte-serial load/store, one-cycle write-back in DONE.
   // Load timing: step_q counts LOAD cycles; the byte issued at step k-1 is
   // on ram_din_i at step k, and the last byte is folded in straight from
   // ram_din_i when the result is registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         addr_q     <= '0;
         sdata_q    <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         rwe_q      <= 1'b0;
         bytes_q    <= '0;
         valid_q    <= 1'b0;
         wd_q       <= '0;
         wreg_q     <= 1'b0;
         wdata_q    <= '0;
         ram_addr_q <= '0;
         ram_wr_q   <= 1'b0;
         ram_dout_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               wreg_q  <= 1'b0;
               if (valid_i) begin
                  if (!is_mem_d) begin
                     valid_q <= 1'b1;
                     wd_q    <= wd_i;
                     wreg_q  <= wreg_i && (wd_i != 5'd0);
                     wdata_q <= wdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
                  end else if (misalign_d) begin
                     state_q    <= ST_DONE;
                     valid_q    <= 1'b1;
                     wd_q       <= '0;
                     wdata_q    <= '0;
                     misalign_q <= 1'b1;
`endif
                  end else begin
                     addr_q     <= wdata_i[ADDR_W-1:0];
                     sdata_q    <= mem_w_data_i;
                     op_q       <= mem_op_i;
                     rd_q       <= wd_i;
                     rwe_q      <= wreg_i && (wd_i != 5'd0);
                     step_q     <= '0;
                     ram_addr_q <= wdata_i[ADDR_W-1:0];
                     if (is_ld_d) begin
                        state_q <= ST_LOAD;
                     end else begin
                        state_q    <= ST_STORE;
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= mem_w_data_i[7:0];
                     end
                  end
               end
            end
            ST_LOAD: begin
               if ((step_q != 3'd0) && (step_q != size_c)) begin
                  case (step_q[1:0])
                     2'd1:    bytes_q[7:0]   <= ram_din_i;
                     2'd2:    bytes_q[15:8]  <= ram_din_i;
                     2'd3:    bytes_q[23:16] <= ram_din_i;
                     default: ;
                  endcase
               end
               if (more_d) ram_addr_q <= addr_nx_d;
               if (step_q == size_c) begin
                  state_q <= ST_DONE;
                  valid_q <= 1'b1;
                  wd_q    <= rd_q;
                  wreg_q  <= rwe_q;
                  wdata_q <= load_data;
               end else begin
                  step_q <= step_nx_d[2:0];
               end
            end
            ST_STORE: begin
               if (more_d) begin
                  ram_addr_q <= addr_nx_d;
                  ram_dout_q <= store_byte_d;
                  step_q     <= step_nx_d[2:0];
               end else begin
                  ram_wr_q <= 1'b0;
                  state_q  <= ST_DONE;
                  valid_q  <= 1'b1;
                  wd_q     <= '0;
                  wreg_q   <= 1'b0;
                  wdata_q  <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               wreg_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
               misalign_q <= 1'b0;
`endif
            end
         endcase
      end
   end

   assign stall_req_o = (state_q == ST_LOAD) || (state_q == ST_STORE) ||
                        ((state_q == ST_IDLE) && valid_i && is_mem_d);

   assign ram_addr_o = ram_addr_q;
   assign ram_wr_o   = ram_wr_q;
   assign ram_dout_o = ram_dout_q;
   assign valid_o    = valid_q;
   assign wd_o       = wd_q;
   assign wreg_o     = wreg_q;
   assign wdata_o    = wdata_q;
   assign fwd_rd_o   = (valid_q && wreg_q && (wd_q != 5'd0)) ? wd_q : 5'd0;
   assign fwd_data_o = (valid_q && wreg_q && (wd_q != 5'd0)) ? wdata_q : '0;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte RAM model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic [4:0]  wd_i = '0;
   logic        wreg_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic [31:0] mem_w_data_i = '0;
   logic [3:0]  mem_op_i = '0;
   logic [7:0]  ram_din_i = '0;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;
   logic [7:0]  ram_dout_o;
   logic        stall_req_o;
   logic        valid_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic [4:0]  fwd_rd_o;
   logic [31:0] fwd_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int total = 0;
   int bad = 0;

   logic [7:0]  mem [0:1023];
   int          wr_cnt = 0;
   logic [31:0] wr_addr [0:15];
   logic [7:0]  wr_data [0:15];

   mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .wd_i         (wd_i),
      .wreg_i       (wreg_i),
      .wdata_i      (wdata_i),
      .mem_w_data_i (mem_w_data_i),
      .mem_op_i     (mem_op_i),
      .ram_din_i    (ram_din_i),
      .ram_addr_o   (ram_addr_o),
      .ram_wr_o     (ram_wr_o),
      .ram_dout_o   (ram_dout_o),
      .stall_req_o  (stall_req_o),
      .valid_o      (valid_o),
      .wd_o         (wd_o),
      .wreg_o       (wreg_o),
      .wdata_o      (wdata_o),
      .fwd_rd_o     (fwd_rd_o),
      .fwd_data_o   (fwd_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_o   (misalign_o)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM: read data one cycle after address, logged writes.
   always @(posedge clk) begin
      if (ram_wr_o) begin
         mem[ram_addr_o[9:0]] <= ram_dout_o;
         if (wr_cnt < 16) begin
            wr_addr[wr_cnt] <= ram_addr_o;
            wr_data[wr_cnt] <= ram_dout_o;
         end
         wr_cnt <= wr_cnt + 1;
      end
      ram_din_i <= mem[ram_addr_o[9:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] wd);
      valid_i      = 1'b1;
      mem_op_i     = op;
      wdata_i      = addr;
      mem_w_data_i = sd;
      wd_i         = wd;
      wreg_i       = 1'b1;
   endtask

   task automatic idle_inputs();
      valid_i  = 1'b0;
      mem_op_i = 4'd0;
      wreg_i   = 1'b0;
   endtask

   // Runs a memory op to completion; reports result and cycles to valid_o.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] wd,
                         output logic [31:0] data, output int lat, output logic seen);
      drive(op, addr, sd, wd);
      seen = 1'b0;
      lat  = 0;
      data = '0;
      for (int i = 1; i <= 12 && !seen; i++) begin
         tick();
         if (valid_o) begin
            seen = 1'b1;
            lat  = i;
            data = wdata_o;
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      tick();
      tick();
      total++;
      if ({valid_o, wreg_o, ram_wr_o, stall_req_o} !== 4'b0000 || ram_addr_o !== 32'h0 ||
          ram_dout_o !== 8'h0 || wdata_o !== 32'h0 || wd_o !== 5'h0 ||
          fwd_rd_o !== 5'h0 || fwd_data_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b wr=%b rw=%b st=%b addr=%h dout=%h wdata=%h wd=%h fwd=%h/%h, want all 0",
                  valid_o, wreg_o, ram_wr_o, stall_req_o, ram_addr_o, ram_dout_o, wdata_o, wd_o, fwd_rd_o, fwd_data_o);
      end
`ifdef MEM_MISALIGN_TRAP_EN
      total++;
      if (misalign_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_misalign: got %b want 0", misalign_o);
      end
`endif
      rst = 1'b1;
      tick();
   endtask

   task automatic test_passthrough();
      logic stalled;
      drive(4'd0, 32'h1234, 32'h0, 5'd5);
      #1;
      stalled = stall_req_o;
      tick();
      stalled = stalled | stall_req_o;
      total++;
      if (valid_o !== 1'b1 || wd_o !== 5'd5 || wreg_o !== 1'b1 || wdata_o !== 32'h1234) begin
         bad++;
         $display("FAIL passthrough: got v=%b wd=%0d wr=%b data=%h want 1/5/1/00001234", valid_o, wd_o, wreg_o, wdata_o);
      end
      total++;
      if (fwd_rd_o !== 5'd5 || fwd_data_o !== 32'h1234) begin
         bad++;
         $display("FAIL passthrough_fwd: got %0d/%h want 5/00001234", fwd_rd_o, fwd_data_o);
      end
      drive(4'd0, 32'hCAFE, 32'h0, 5'd0);
      tick();
      stalled = stalled | stall_req_o;
      total++;
      if (valid_o !== 1'b1 || wreg_o !== 1'b0 || fwd_rd_o !== 5'd0 || wdata_o !== 32'hCAFE) begin
         bad++;
         $display("FAIL passthrough_x0: got v=%b wr=%b fwd=%0d data=%h want 1/0/0/0000cafe", valid_o, wreg_o, fwd_rd_o, wdata_o);
      end
      idle_inputs();
      tick();
      total++;
      if (valid_o !== 1'b0 || fwd_rd_o !== 5'd0 || stalled !== 1'b0) begin
         bad++;
         $display("FAIL passthrough_idle: got v=%b fwd=%0d stall_seen=%b want 0/0/0", valid_o, fwd_rd_o, stalled);
      end
   endtask

   task automatic test_lw();
      logic [31:0] want_addr;
      mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
      drive(4'd3, 32'h100, 32'h0, 5'd3);
      #1;
      total++;
      if (stall_req_o !== 1'b1) begin
         bad++;
         $display("FAIL lw_stall_accept: got %b want 1", stall_req_o);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c <= 4) begin
            want_addr = 32'h100 + 32'(c - 1);
            total++;
            if (ram_addr_o !== want_addr || ram_wr_o !== 1'b0 || stall_req_o !== 1'b1) begin
               bad++;
               $display("FAIL lw_issue%0d: got addr=%h wr=%b st=%b want %h/0/1", c, ram_addr_o, ram_wr_o, stall_req_o, want_addr);
            end
         end
         if (c < 6) begin
            total++;
            if (valid_o !== 1'b0 || fwd_rd_o !== 5'd0) begin
               bad++;
               $display("FAIL lw_early%0d: got v=%b fwd=%0d want 0/0", c, valid_o, fwd_rd_o);
            end
         end
      end
      total++;
      if (valid_o !== 1'b1 || wdata_o !== 32'h12345678 || wd_o !== 5'd3 || wreg_o !== 1'b1 ||
          fwd_rd_o !== 5'd3 || fwd_data_o !== 32'h12345678 || stall_req_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_done: got v=%b data=%h wd=%0d wr=%b fwd=%0d/%h st=%b want 1/12345678/3/1/3/12345678/0",
                  valid_o, wdata_o, wd_o, wreg_o, fwd_rd_o, fwd_data_o, stall_req_o);
      end
      tick();
      idle_inputs();
      total++;
      if (valid_o !== 1'b0) begin
         bad++;
         $display("FAIL lw_one_cycle: got v=%b want 0", valid_o);
      end
      tick();
   endtask

   task automatic test_byte_half();
      logic [31:0] d;
      int          lat;
      logic        seen;
      mem[10'h020] = 8'h80;
      mem[10'h030] = 8'h01; mem[10'h031] = 8'h80;
      run_op(4'd1, 32'h20, 32'h0, 5'd4, d, lat, seen);
      total++;
      if (!seen || d !== 32'hFFFFFF80 || lat != 3) begin
         bad++;
         $display("FAIL lb: got seen=%b data=%h lat=%0d want 1/ffffff80/3", seen, d, lat);
      end
      tick();
      run_op(4'd4, 32'h20, 32'h0, 5'd4, d, lat, seen);
      total++;
      if (!seen || d !== 32'h00000080) begin
         bad++;
         $display("FAIL lbu: got seen=%b data=%h want 1/00000080", seen, d);
      end
      tick();
      run_op(4'd2, 32'h30, 32'h0, 5'd6, d, lat, seen);
      total++;
      if (!seen || d !== 32'hFFFF8001 || lat != 4) begin
         bad++;
         $display("FAIL lh: got seen=%b data=%h lat=%0d want 1/ffff8001/4", seen, d, lat);
      end
      tick();
      run_op(4'd5, 32'h30, 32'h0, 5'd6, d, lat, seen);
      total++;
      if (!seen || d !== 32'h00008001) begin
         bad++;
         $display("FAIL lhu: got seen=%b data=%h want 1/00008001", seen, d);
      end
      tick();
   endtask

   task automatic test_sh();
      logic [31:0] d;
      int          lat;
      logic        seen;
      wr_cnt = 0;
      run_op(4'd7, 32'h40, 32'hAABBCCDD, 5'd7, d, lat, seen);
      total++;
      if (!seen || wreg_o !== 1'b0 || wd_o !== 5'd0 || fwd_rd_o !== 5'd0 || ram_wr_o !== 1'b0) begin
         bad++;
         $display("FAIL sh_done: got seen=%b wr=%b wd=%0d fwd=%0d ramwr=%b want 1/0/0/0/0", seen, wreg_o, wd_o, fwd_rd_o, ram_wr_o);
      end
      tick();
      tick();
      total++;
      if (wr_cnt != 2 || wr_addr[0] !== 32'h40 || wr_data[0] !== 8'hDD ||
          wr_addr[1] !== 32'h41 || wr_data[1] !== 8'hCC) begin
         bad++;
         $display("FAIL sh_writes: got n=%0d (%h,%h) (%h,%h) want 2 (00000040,dd) (00000041,cc)",
                  wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_reset_mid_sw();
      for (int i = 0; i < 4; i++) mem[10'h060 + i] = 8'h00;
      wr_cnt = 0;
      drive(4'd8, 32'h60, 32'h44332211, 5'd9);
      tick();
      tick();
      total++;
      if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h61 || ram_dout_o !== 8'h22) begin
         bad++;
         $display("FAIL sw_byte2: got wr=%b addr=%h dout=%h want 1/00000061/22", ram_wr_o, ram_addr_o, ram_dout_o);
      end
      rst = 1'b0;
      idle_inputs();
      tick();
      total++;
      if (ram_wr_o !== 1'b0 || stall_req_o !== 1'b0 || valid_o !== 1'b0) begin
         bad++;
         $display("FAIL sw_reset: got wr=%b st=%b v=%b want 0/0/0", ram_wr_o, stall_req_o, valid_o);
      end
      rst = 1'b1;
      tick();
      tick();
      tick();
      total++;
      if (wr_cnt != 2 || mem[10'h062] !== 8'h00 || mem[10'h061] !== 8'h22 || ram_wr_o !== 1'b0) begin
         bad++;
         $display("FAIL sw_no_third: got writes=%0d mem62=%h mem61=%h wr=%b want 2/00/22/0", wr_cnt, mem[10'h062], mem[10'h061], ram_wr_o);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] d;
      int          lat;
      logic        seen;
`ifdef MEM_MISALIGN_TRAP_EN
      wr_cnt = 0;
      drive(4'd3, 32'h102, 32'h0, 5'd3);
      tick();
      total++;
      if (valid_o !== 1'b1 || misalign_o !== 1'b1 || wreg_o !== 1'b0 || ram_wr_o !== 1'b0 || stall_req_o !== 1'b0) begin
         bad++;
         $display("FAIL misalign_trap: got v=%b mis=%b wr=%b ramwr=%b st=%b want 1/1/0/0/0",
                  valid_o, misalign_o, wreg_o, ram_wr_o, stall_req_o);
      end
      tick();
      idle_inputs();
      total++;
      if (valid_o !== 1'b0 || misalign_o !== 1'b0 || wr_cnt != 0) begin
         bad++;
         $display("FAIL misalign_clear: got v=%b mis=%b writes=%0d want 0/0/0", valid_o, misalign_o, wr_cnt);
      end
      tick();
`else
      mem[10'h104] = 8'hAB;
      run_op(4'd3, 32'h101, 32'h0, 5'd8, d, lat, seen);
      total++;
      if (!seen || d !== 32'hAB123456 || lat != 6) begin
         bad++;
         $display("FAIL misaligned_lw: got seen=%b data=%h lat=%0d want 1/ab123456/6", seen, d, lat);
      end
      tick();
      mem[10'h3FF] = 8'h11; mem[10'h000] = 8'h22;
      run_op(4'd5, 32'hFFFFFFFF, 32'h0, 5'd8, d, lat, seen);
      total++;
      if (!seen || d !== 32'h00002211) begin
         bad++;
         $display("FAIL wrap_lhu: got seen=%b data=%h want 1/00002211", seen, d);
      end
      tick();
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset();
      test_passthrough();
      test_lw();
      test_byte_half();
      test_sh();
      test_reset_mid_sw();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
